rggen_wishbone_adapter: RTL and testbench
=========================================

// Module: rggen_wishbone_adapter
//
// PURPOSE
//  Wishbone B4 slave front end for an rggen register block: accepts one Wishbone access at a time and turns it into an rggen bus request.
//  Registers the request, drives it on the rggen bus until i_bus_ready, then returns ACK or ERR with read data.
//  Sits between a system Wishbone interconnect and the register block's rggen bus input.
//  It is the responder-side counterpart of rggen_wishbone_bridge.
//
// PARAMETERS
//  ADDRESS_WIDTH  8   width of i_wb_adr / o_bus_address
//  BUS_WIDTH      32  data width; strobe/sel width is BUS_WIDTH/8
//  USE_STALL      1   1: pipelined mode, o_wb_stall used; 0: classic mode, o_wb_stall tied 0
//
// PORTS
//  i_clk             in   1             clock, all logic on rising edge
//  i_rst             in   1             synchronous reset, active-high
//  i_wb_cyc          in   1             Wishbone cycle
//  i_wb_stb          in   1             Wishbone strobe
//  o_wb_stall        out  1             Wishbone stall (pipelined mode)
//  i_wb_adr          in   ADDRESS_WIDTH Wishbone address
//  i_wb_we           in   1             Wishbone write enable
//  i_wb_dat          in   BUS_WIDTH     Wishbone write data
//  i_wb_sel          in   BUS_WIDTH/8   Wishbone byte select
//  o_wb_ack          out  1             Wishbone ack, 1-cycle pulse
//  o_wb_err          out  1             Wishbone error, 1-cycle pulse
//  o_wb_rty          out  1             Wishbone retry, constant 0
//  o_wb_dat          out  BUS_WIDTH     Wishbone read data
//  o_bus_valid       out  1             rggen request valid
//  o_bus_access      out  2             RGGEN_WRITE if we, else RGGEN_READ
//  o_bus_address     out  ADDRESS_WIDTH rggen address
//  o_bus_write_data  out  BUS_WIDTH     rggen write data
//  o_bus_strobe      out  BUS_WIDTH/8   rggen byte strobe
//  i_bus_ready       in   1             rggen response valid
//  i_bus_status      in   2             rggen status; bit1=1 is an error (SLAVE_ERROR/DECODE_ERROR)
//  i_bus_read_data   in   BUS_WIDTH     rggen read data
//
// BEHAVIOUR
//  Reset (i_rst=1 at an edge):
//   - state=IDLE; every output and request register is 0, except o_wb_stall, which follows the state decode (0 in IDLE).
//  FSM states: IDLE, BUSY, RESP.
//  IDLE:
//   - o_wb_stall=0. At the edge where cyc&&stb=1, capture adr/we/dat/sel and go to BUSY.
//  BUSY:
//   - o_bus_valid=1; request outputs stay stable until i_bus_ready.
//   - o_wb_stall=USE_STALL; stb pulses from the master are ignored.
//   - At the edge where i_bus_ready=1: capture status and read data, drop o_bus_valid, go to RESP.
//  RESP:
//   - o_wb_ack=i_wb_cyc&&!status[1]; o_wb_err=i_wb_cyc&&status[1].
//   - o_wb_dat=captured read data for reads, 0 for writes; 0 in all other states.
//   - o_wb_stall=USE_STALL. Unconditional return to IDLE at the next edge.
//  Latency:
//   - stb accepted at edge N -> o_bus_valid high from cycle N+1.
//   - i_bus_ready at edge M -> ack/err high in cycle M+1 only.
//   - Minimum stb-to-ack is 2 cycles.
//  Rules:
//   - One outstanding access; no queueing.
//   - In classic mode the master holds stb until ack. The next IDLE cycle samples fresh stb, so one access is never accepted twice.
//   - cyc dropped in BUSY: the rggen access still completes (valid is never withdrawn); ack/err are suppressed in RESP.
//   - cyc dropped in RESP: ack/err=0; FSM still returns to IDLE.
//   - o_wb_rty is always 0. o_bus_access takes only RGGEN_READ or RGGEN_WRITE.
//   - Reset mid-access: abandon at once; o_bus_valid=0 in the next cycle; no response is emitted.
//
// TESTING
//  1. Write: adr=0x10, dat=0xA5A5_0001, sel=4'hF, ready 3 cycles after valid, status=OKAY -> bus sees WRITE/0x10/same data; one ack; err=0.
//  2. Read: adr=0x24; ready returns read_data=0x1234_5678 with OKAY -> ack pulse with o_wb_dat=0x1234_5678; o_wb_dat=0 the next cycle.
//  3. Error: status=SLAVE_ERROR (2'b10), then DECODE_ERROR (2'b11) -> err pulse, ack=0 for both.
//  4. Pipelined back-to-back stb, USE_STALL=1 -> stall=1 in BUSY/RESP; second access accepted only in the following IDLE; two ordered responses.
//  5. Classic mode, USE_STALL=0 -> stall constant 0; stb held through ack gives exactly one rggen request per ack.
//  6. cyc dropped in BUSY, then i_rst pulsed in BUSY -> no ack/err; valid held until ready (first case); valid=0 the cycle after reset (second case).

Source files
------------

// File: rtl/rggen_wishbone_adapter.sv
// Wishbone B4 slave front end for an rggen register block.
// One access at a time: capture, drive rggen request, answer ACK/ERR.
module rggen_wishbone_adapter #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter bit USE_STALL     = 1'b1
)(
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wb_cyc,
    input  logic                       i_wb_stb,
    output logic                       o_wb_stall,
    input  logic [ADDRESS_WIDTH-1:0]   i_wb_adr,
    input  logic                       i_wb_we,
    input  logic [BUS_WIDTH-1:0]       i_wb_dat,
    input  logic [BUS_WIDTH/8-1:0]     i_wb_sel,
    output logic                       o_wb_ack,
    output logic                       o_wb_err,
    output logic                       o_wb_rty,
    output logic [BUS_WIDTH-1:0]       o_wb_dat,
    output logic                       o_bus_valid,
    output logic [1:0]                 o_bus_access,
    output logic [ADDRESS_WIDTH-1:0]   o_bus_address,
    output logic [BUS_WIDTH-1:0]       o_bus_write_data,
    output logic [BUS_WIDTH/8-1:0]     o_bus_strobe,
    input  logic                       i_bus_ready,
    input  logic [1:0]                 i_bus_status,
    input  logic [BUS_WIDTH-1:0]       i_bus_read_data
);

    localparam int         STROBE_WIDTH = BUS_WIDTH / 8;
    localparam logic [1:0] RGGEN_READ   = 2'b10;
    localparam logic [1:0] RGGEN_WRITE  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                     state_q;
    logic                       valid_q;
    logic                       we_q;
    logic [1:0]                 access_q;
    logic [ADDRESS_WIDTH-1:0]   address_q;
    logic [BUS_WIDTH-1:0]       write_data_q;
    logic [STROBE_WIDTH-1:0]    strobe_q;
    logic [1:0]                 status_q;
    logic [BUS_WIDTH-1:0]       read_data_q;

    logic                       in_resp;
    logic                       unused_status;

    // Request capture, rggen handshake and response sequencing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            valid_q      <= 1'b0;
            we_q         <= 1'b0;
            access_q     <= 2'b00;
            address_q    <= '0;
            write_data_q <= '0;
            strobe_q     <= '0;
            status_q     <= 2'b00;
            read_data_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_wb_cyc && i_wb_stb) begin
                        valid_q      <= 1'b1;
                        we_q         <= i_wb_we;
                        access_q     <= i_wb_we ? RGGEN_WRITE : RGGEN_READ;
                        address_q    <= i_wb_adr;
                        write_data_q <= i_wb_dat;
                        strobe_q     <= i_wb_sel;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    if (i_bus_ready) begin
                        valid_q     <= 1'b0;
                        status_q    <= i_bus_status;
                        read_data_q <= i_bus_read_data;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Response decode; ack/err are gated by the live cycle signal.
    always_comb begin
        in_resp    = (state_q == RESP);
        o_wb_stall = USE_STALL && (state_q != IDLE);
        o_wb_ack   = in_resp && i_wb_cyc && !status_q[1];
        o_wb_err   = in_resp && i_wb_cyc && status_q[1];
        o_wb_rty   = 1'b0;
        o_wb_dat   = (in_resp && !we_q) ? read_data_q : '0;
    end

    assign o_bus_valid      = valid_q;
    assign o_bus_access     = access_q;
    assign o_bus_address    = address_q;
    assign o_bus_write_data = write_data_q;
    assign o_bus_strobe     = strobe_q;

    // Only the error bit of the status matters to Wishbone.
    assign unused_status = status_q[0];

endmodule

// File: tb/tb_rggen_wishbone_adapter.sv
// Bench for rggen_wishbone_adapter: pipelined and classic instances
// share stimulus; a scoreboard checks requests and responses.
module tb_rggen_wishbone_adapter;

    localparam logic [1:0] RD = 2'b10;
    localparam logic [1:0] WR = 2'b11;

    typedef struct {
        int         dly;
        logic [1:0] st;
        logic [31:0] rd;
    } plan_t;

    typedef struct {
        logic [1:0]  acc;
        logic [7:0]  adr;
        logic [31:0] wd;
        logic [3:0]  sb;
    } req_t;

    typedef struct {
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [7:0]  adr = '0;
    logic        we  = 1'b0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = '0;
    logic        ready = 1'b0;
    logic [1:0]  status = '0;
    logic [31:0] rdata = '0;

    logic        stall1, ack1, err1, rty1, valid1;
    logic [31:0] dat1, bwd1;
    logic [1:0]  acc1;
    logic [7:0]  badr1;
    logic [3:0]  bsb1;

    logic        stall0, ack0, err0, rty0, valid0;
    logic [31:0] dat0, bwd0;
    logic [1:0]  acc0;
    logic [7:0]  badr0;
    logic [3:0]  bsb0;

    int total = 0;
    int bad   = 0;
    bit drop_mode = 1'b0;

    plan_t plan_q[$];
    req_t  req_q[$];
    rsp_t  rsp_q[$];
    logic [31:0] mem [256];

    always #5 clk = ~clk;

    rggen_wishbone_adapter #(
        .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .USE_STALL(1'b1)
    ) dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .o_wb_stall(stall1),
        .i_wb_adr(adr), .i_wb_we(we), .i_wb_dat(wdat), .i_wb_sel(sel),
        .o_wb_ack(ack1), .o_wb_err(err1), .o_wb_rty(rty1),
        .o_wb_dat(dat1),
        .o_bus_valid(valid1), .o_bus_access(acc1),
        .o_bus_address(badr1), .o_bus_write_data(bwd1),
        .o_bus_strobe(bsb1),
        .i_bus_ready(ready), .i_bus_status(status),
        .i_bus_read_data(rdata)
    );

    rggen_wishbone_adapter #(
        .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .USE_STALL(1'b0)
    ) dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .o_wb_stall(stall0),
        .i_wb_adr(adr), .i_wb_we(we), .i_wb_dat(wdat), .i_wb_sel(sel),
        .o_wb_ack(ack0), .o_wb_err(err0), .o_wb_rty(rty0),
        .o_wb_dat(dat0),
        .o_bus_valid(valid0), .o_bus_access(acc0),
        .o_bus_address(badr0), .o_bus_write_data(bwd0),
        .o_bus_strobe(bsb0),
        .i_bus_ready(ready), .i_bus_status(status),
        .i_bus_read_data(rdata)
    );

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, a, e, $time);
        end
    endtask

    task automatic check_req(input req_t r);
        chk("bus_access", {acc1, acc0}, {r.acc, r.acc});
        chk("bus_address", {badr1, badr0}, {r.adr, r.adr});
        chk("bus_wdata", {bwd1, bwd0}, {r.wd, r.wd});
        chk("bus_strobe", {bsb1, bsb0}, {r.sb, r.sb});
    endtask

    // mode: 0 stb pulse, 1 stb held (classic), 4 stb held with junk,
    //       2 cyc dropped while busy, 3 reset while busy
    task automatic access(input bit w, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] st, input int dly,
                          input int mode);
        logic [31:0] rd;
        bit done;
        rd = (w || st[1]) ? 32'($urandom) : mem[a];
        plan_q.push_back('{dly, st, rd});
        req_q.push_back('{w ? WR : RD, a, d, s});
        if (mode != 2 && mode != 3)
            rsp_q.push_back('{st[1], w ? 32'h0 : rd});
        if (w && !st[1] && mode != 3)
            for (int b = 0; b < 4; b++)
                if (s[b]) mem[a][b*8 +: 8] = d[b*8 +: 8];
        chk("stall_idle", {stall1, stall0}, 2'b00);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        @(posedge clk); #1;
        if (mode == 0 || mode == 4) begin
            stb  = (mode == 4);
            we   = 1'($urandom);
            adr  = 8'($urandom);
            wdat = 32'($urandom);
            sel  = 4'($urandom);
        end
        if (mode == 3) begin
            @(posedge clk); #1;
            rst = 1'b1; cyc = 1'b0; stb = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            chk("valid_after_rst", {valid1, valid0}, 2'b00);
            return;
        end
        if (mode == 2) begin
            cyc = 1'b0; stb = 1'b0; drop_mode = 1'b1;
            done = 1'b0;
            for (int n = 0; n < 60; n++) begin
                @(negedge clk);
                if (!valid1) begin done = 1'b1; break; end
            end
            chk("drop_done", 64'(done), 64'd1);
            @(posedge clk); #1;
            drop_mode = 1'b0;
            return;
        end
        done = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            chk("stall_busy", {stall1, stall0}, 2'b10);
            if (ack1 | err1 | ack0 | err0) begin done = 1'b1; break; end
        end
        chk("rsp_seen", 64'(done), 64'd1);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
    endtask

    // rggen-side responder driven from the stimulus plan
    initial begin
        int    cnt;
        bit    busy;
        plan_t p;
        req_t  r;
        busy = 1'b0;
        cnt  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin busy = 1'b0; ready = 1'b0; continue; end
            if (!busy && valid1) begin
                if (plan_q.size() == 0 || req_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_request adr=%0h t=%0t",
                             badr1, $time);
                    p = '{0, 2'b00, 32'h0};
                    r = '{acc1, badr1, bwd1, bsb1};
                end else begin
                    p = plan_q.pop_front();
                    r = req_q.pop_front();
                end
                check_req(r);
                cnt  = p.dly;
                busy = 1'b1;
            end
            if (busy) begin
                chk("valid_held", {valid1, valid0}, 2'b11);
                if (cnt == 0) begin
                    check_req(r);
                    ready = 1'b1; status = p.st; rdata = p.rd;
                    busy = 1'b0;
                end else begin
                    cnt--;
                    ready = 1'b0;
                    status = 2'($urandom); rdata = 32'($urandom);
                end
            end else begin
                ready = 1'b0;
                status = 2'($urandom); rdata = 32'($urandom);
            end
        end
    end

    // response monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst) continue;
            chk("rty_stall0", {rty1, rty0, stall0}, 3'b000);
            if (ack1 | err1 | ack0 | err0) begin
                if (rsp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_response ack=%0b err=%0b t=%0t",
                             ack1, err1, $time);
                end else begin
                    e = rsp_q.pop_front();
                    chk("ack_err1", {ack1, err1}, {!e.err, e.err});
                    chk("ack_err0", {ack0, err0}, {!e.err, e.err});
                    chk("wb_dat", {dat1, dat0}, {e.dat, e.dat});
                end
            end else if (!drop_mode) begin
                chk("wb_dat_idle", {dat1, dat0}, 64'h0);
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int mode;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h24] = 32'h1234_5678;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wb", {ack1, err1, rty1, stall1, ack0, err0, rty0, stall0},
            8'h00);
        chk("rst_dat", {dat1, dat0}, 64'h0);
        chk("rst_bus", {valid1, acc1, badr1, bsb1, valid0, acc0, badr0, bsb0},
            30'h0);
        chk("rst_wd", {bwd1, bwd0}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        access(1'b1, 8'h10, 32'hA5A5_0001, 4'hF, 2'b00, 3, 0);
        access(1'b0, 8'h24, 32'h0, 4'hF, 2'b00, 1, 0);
        access(1'b0, 8'h10, 32'h0, 4'hF, 2'b10, 0, 0);
        access(1'b1, 8'h30, 32'hDEAD_BEEF, 4'h3, 2'b11, 2, 1);
        access(1'b1, 8'h40, 32'h0BAD_F00D, 4'hF, 2'b00, 0, 4);
        access(1'b0, 8'h40, 32'h0, 4'hF, 2'b01, 2, 4);
        access(1'b0, 8'h10, 32'h0, 4'hF, 2'b00, 0, 1);
        access(1'b1, 8'h50, 32'h1111_2222, 4'h5, 2'b00, 3, 1);
        access(1'b0, 8'h24, 32'h0, 4'hF, 2'b00, 4, 2);
        access(1'b1, 8'h60, 32'h3333_4444, 4'hF, 2'b00, 5, 3);
        access(1'b0, 8'h50, 32'h0, 4'hF, 2'b00, 0, 0);

        for (int i = 0; i < 200; i++) begin
            mode = int'($urandom_range(0, 9));
            if (mode > 4) mode = 0;
            access(1'($urandom), 8'($urandom_range(0, 15)),
                   32'($urandom), 4'($urandom), 2'($urandom),
                   (mode == 3) ? 5 : int'($urandom_range(0, 4)), mode);
        end

        repeat (5) @(posedge clk);
        chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        chk("req_q_empty", 64'(req_q.size() + plan_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
